// File: rtl/iterative_alu.sv
// rtl/iterative_alu.sv - multi-cycle ALU: single-cycle logic/arith ops, bit-serial shifts
// Shifts take one cycle per bit; every result is held in DONE until the consumer accepts it.
module iterative_alu (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  ALUControl,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] ALUResult,
  output logic        Zero,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_result;
  logic [31:0] r_work;
  logic [4:0]  r_cnt;
  logic        r_arith;

  logic        w_accept;
  logic        w_is_shift;
  logic        w_multi_cycle;
  logic [4:0]  w_shamt;
  logic [31:0] w_alu;
  logic [31:0] w_work_next;

  assign w_accept      = in_valid & (r_state == IDLE);
  assign w_shamt       = SrcB[4:0];
  assign w_is_shift    = ALUControl[2] & ALUControl[1];
  assign w_multi_cycle = w_is_shift & (w_shamt != 5'd0);
  // sra refills from the sign bit, srl from zero
  assign w_work_next   = {r_arith ? r_work[31] : 1'b0, r_work[31:1]};

  // Shift codes pass SrcA through so a zero shift amount completes in one cycle.
  always_comb begin
    w_alu = 32'd0;
    case (ALUControl)
      3'b000:  w_alu = SrcA + SrcB;
      3'b001:  w_alu = SrcA - SrcB;
      3'b010:  w_alu = SrcA & SrcB;
      3'b011:  w_alu = SrcA | SrcB;
      3'b100:  w_alu = SrcA ^ SrcB;
      3'b101:  w_alu = {31'd0, ($signed(SrcA) < $signed(SrcB))};
      default: w_alu = SrcA;
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next_state = w_multi_cycle ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        if (r_cnt == 5'd1) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_result <= 32'd0;
      r_work   <= 32'd0;
      r_cnt    <= 5'd0;
      r_arith  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_multi_cycle) begin
              r_work  <= SrcA;
              r_cnt   <= w_shamt;
              r_arith <= ~ALUControl[0];
            end else begin
              r_result <= w_alu;
            end
          end
        end
        SHIFT: begin
          r_work <= w_work_next;
          r_cnt  <= r_cnt - 5'd1;
          if (r_cnt == 5'd1) begin
            r_result <= w_work_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign out_valid = (r_state == DONE);
  assign ALUResult = r_result;
  assign Zero      = (r_result == 32'd0);

endmodule

// File: tb/tb_iterative_alu.sv
// tb/tb_iterative_alu.sv - randomized self-checking bench for iterative_alu
// Expected results and latencies come from a plain-arithmetic reference model.
module tb_iterative_alu;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  ALUControl;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALUResult;
  logic        Zero;
  logic        busy;

  int n_pass;
  int n_total;

  iterative_alu dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ALUControl (ALUControl),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ALUResult  (ALUResult),
    .Zero       (Zero),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [2:0] ctrl, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    case (ctrl)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return (sa < sb) ? 32'd1 : 32'd0;
      3'd6:    return sa >>> b[4:0];
      default: return a >> b[4:0];
    endcase
  endfunction

  // Cycles from the accept cycle to the first cycle with out_valid high.
  function automatic int ref_latency(input logic [2:0] ctrl, input logic [31:0] b);
    if (ctrl >= 3'd6 && b[4:0] != 5'd0) return int'(b[4:0]) + 1;
    return 1;
  endfunction

  task automatic run_op(input string name, input logic [2:0] ctrl, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    logic [31:0] exp;
    int lat;
    int cycles;
    bit busy_ok;
    bit stable_ok;
    exp = ref_alu(ctrl, a, b);
    lat = ref_latency(ctrl, b);

    @(negedge clk);
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL %s in_ready before accept: got %b want 1", name, in_ready);
    else n_pass++;
    in_valid = 1'b1; ALUControl = ctrl; SrcA = a; SrcB = b;
    @(negedge clk);
    cycles = 1;
    busy_ok = 1'b1;
    while (out_valid !== 1'b1 && cycles < 64) begin
      if (in_ready !== 1'b0 || busy !== 1'b1) busy_ok = 1'b0;
      in_valid = 1'($urandom); ALUControl = 3'($urandom); SrcA = $urandom; SrcB = $urandom;
      @(negedge clk);
      cycles++;
    end
    n_total++;
    if (cycles !== lat) $display("FAIL %s latency: got %0d want %0d", name, cycles, lat);
    else n_pass++;
    n_total++;
    if (!busy_ok) $display("FAIL %s busy/in_ready during shift: got not busy want busy", name);
    else n_pass++;
    n_total++;
    if (ALUResult !== exp) $display("FAIL %s result: got %h want %h", name, ALUResult, exp);
    else n_pass++;
    n_total++;
    if (Zero !== (exp == 32'd0)) $display("FAIL %s Zero: got %b want %b", name, Zero, exp == 32'd0);
    else n_pass++;
    n_total++;
    if (in_ready !== 1'b0 || busy !== 1'b1)
      $display("FAIL %s DONE flags: got in_ready=%b busy=%b want 0/1", name, in_ready, busy);
    else n_pass++;

    stable_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom); ALUControl = 3'($urandom); SrcA = $urandom; SrcB = $urandom;
      @(negedge clk);
      if (out_valid !== 1'b1 || ALUResult !== exp) stable_ok = 1'b0;
    end
    n_total++;
    if (!stable_ok) $display("FAIL %s hold stable: got out_valid=%b result=%h want 1/%h",
                             name, out_valid, ALUResult, exp);
    else n_pass++;

    // A request offered in the handshake cycle must not be taken.
    out_ready = 1'b1; in_valid = 1'b1; ALUControl = 3'd0; SrcA = 32'd1; SrcB = 32'd1;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0;
    n_total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL %s after handshake: got out_valid=%b in_ready=%b busy=%b want 0/1/0",
               name, out_valid, in_ready, busy);
    else n_pass++;
    n_total++;
    if (ALUResult !== exp) $display("FAIL %s idle retain: got %h want %h", name, ALUResult, exp);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    ALUControl = 3'd0; SrcA = 32'd0; SrcB = 32'd0;
    repeat (2) @(negedge clk);
    n_total++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || Zero !== 1'b1 || ALUResult !== 32'd0)
      $display("FAIL reset state: got rdy=%b busy=%b ov=%b zero=%b res=%h want 1/0/0/1/0",
               in_ready, busy, out_valid, Zero, ALUResult);
    else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_directed();
    run_op("add", 3'b000, 32'd5, 32'd7, 0);
    run_op("sub", 3'b001, 32'd9, 32'd9, 0);
    run_op("sra4", 3'b110, 32'h8000_0000, 32'd4, 1);
    run_op("srl31", 3'b111, 32'h8000_0000, 32'd31, 0);
    run_op("srl0", 3'b111, 32'h0000_1234, 32'd0, 0);
    run_op("sra0", 3'b110, 32'h8765_4321, 32'h0000_0020, 0);
  endtask

  task automatic test_backpressure();
    run_op("slt_hold", 3'b101, 32'hFFFF_FFFF, 32'd1, 3);
  endtask

  task automatic test_reset_mid_shift();
    bit quiet;
    @(negedge clk);
    in_valid = 1'b1; ALUControl = 3'b111; SrcA = 32'hDEAD_BEEF; SrcB = 32'd20;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || ALUResult !== 32'd0 || Zero !== 1'b1 || busy !== 1'b0)
      $display("FAIL mid_shift reset: got ov=%b rdy=%b res=%h zero=%b busy=%b want 0/1/0/1/0",
               out_valid, in_ready, ALUResult, Zero, busy);
    else n_pass++;
    quiet = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || ALUResult !== 32'd0) quiet = 1'b0;
    end
    n_total++;
    if (!quiet) $display("FAIL stale result after reset: got ov=%b res=%h want 0/0", out_valid, ALUResult);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [2:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 40; i++) begin
      c = 3'($urandom);
      a = $urandom;
      b = (i % 4 == 0) ? a : $urandom;
      run_op("random", c, a, b, int'($urandom_range(0, 2)));
    end
  endtask

  task automatic test_back_to_back();
    run_op("b2b_xor", 3'b100, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 0);
    run_op("b2b_or", 3'b011, 32'h0F00_0000, 32'h0000_00F0, 0);
    run_op("b2b_and", 3'b010, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0);
    run_op("b2b_sra1", 3'b110, 32'h4000_0001, 32'd1, 0);
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_shift();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/iterative_alu.md
ITERATIVE_ALU -- requirements
Module: iterative_alu

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  reset; synchronous, active-high.
REQ-003 SHALL have port in_valid  input  1  operation request present.
REQ-004 SHALL have port in_ready  output  1  block can accept a request.
REQ-005 SHALL have port ALUControl  input  3  operation code from ALU decoder.
REQ-006 SHALL have port SrcA  input  32  operand A.
REQ-007 SHALL have port SrcB  input  32  operand B; shift amount = SrcB[4:0].
REQ-008 SHALL have port out_valid  output  1  ALUResult valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts result.
REQ-010 SHALL have port ALUResult  output  32  registered result.
REQ-011 SHALL have port Zero  output  1  high when ALUResult == 0.
REQ-012 SHALL have port busy  output  1  high whenever state != IDLE.

Function
REQ-013 SHALL decode ALUControl: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt (signed), 110 sra, 111 srl.
REQ-014 SHALL implement states IDLE, SHIFT, DONE; in_ready = 1 only in IDLE.
REQ-015 SHALL accept a request on the edge where in_valid & in_ready; ALUControl, SrcA, SrcB sampled only at that edge, later changes ignored.
REQ-016 Non-shift op accepted: SHALL register ALUResult and go IDLE->DONE at the accept edge (latency 1: out_valid high the cycle after accept).
REQ-017 add/sub SHALL wrap modulo 2^32, no overflow flag; slt SHALL give 32'd1 if signed(A) < signed(B), else 32'd0.
REQ-018 Shift op with shamt = 0: SHALL load ALUResult = SrcA and go IDLE->DONE (latency 1).
REQ-019 Shift op with shamt = n (1..31): SHALL load working reg = SrcA, 5-bit counter = n, go IDLE->SHIFT.
REQ-020 In SHIFT each edge SHALL shift working reg right one bit (sra replicates bit 31, srl inserts 0) and decrement counter; on the edge where counter == 1, SHALL go SHIFT->DONE with final value in ALUResult (latency n+1).
REQ-021 In DONE out_valid SHALL be 1 and ALUResult/Zero held stable until out_valid & out_ready; at that edge SHALL go DONE->IDLE and drop out_valid.
REQ-022 SHALL NOT accept a new request in the cycle of result handshake (in_ready low in DONE); next accept earliest the following cycle.
REQ-023 Zero SHALL be combinational from ALUResult (1 when ALUResult == 32'h0).
REQ-024 in_valid asserted while in SHIFT or DONE SHALL have no effect.
REQ-025 ALUResult SHALL NOT change in IDLE; it retains last result.

Reset
REQ-026 reset high at a rising edge SHALL force state IDLE, out_valid 0, ALUResult 32'h0, counter 0, regardless of state (including mid-SHIFT; pending op discarded).
REQ-027 During and after reset: in_ready 1, busy 0, Zero 1.
REQ-028 reset SHALL take priority over a simultaneous accept or result handshake.

Verification
REQ-029 add: A=5, B=7, ALUControl=000 -> ALUResult=12, Zero=0, out_valid 1 cycle after accept.
REQ-030 sub: A=9, B=9, ALUControl=001 -> ALUResult=0, Zero=1, latency 1.
REQ-031 sra: A=32'h80000000, B=4, ALUControl=110 -> ALUResult=32'hF8000000 after 5 cycles; in_ready/busy low/high throughout.
REQ-032 srl: A=32'h80000000, B=31, ALUControl=111 -> ALUResult=32'h00000001, out_valid 32 cycles after accept; shamt 0 case A=32'h1234 -> 32'h1234, latency 1.
REQ-033 slt: A=32'hFFFFFFFF, B=1, ALUControl=101 -> ALUResult=1; out_ready held low 3 cycles -> out_valid and ALUResult stay constant, IDLE entered only on handshake edge.
REQ-034 reset pulsed 3 cycles into srl by 20 -> next cycle out_valid=0, in_ready=1, ALUResult=0, Zero=1; no stale result later appears.
